// File: rtl/rat_flags.sv
// RAT status flags (C/Z with shadows), interrupt enable, and synchronized interrupt pending latch.
// Every output is registered or a pure AND of registers; flag commands take effect on the next edge.
module rat_flags #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic C_IN,
    input  logic Z_IN,
    input  logic FLG_C_LD,
    input  logic FLG_C_SET,
    input  logic FLG_C_CLR,
    input  logic FLG_Z_LD,
    input  logic FLG_LD_SEL,
    input  logic FLG_SHAD_LD,
    input  logic I_SET,
    input  logic I_CLR,
    input  logic INTR,
    input  logic INT_ACK,
    output logic C_FLAG,
    output logic Z_FLAG,
    output logic I_FLAG,
    output logic INT_OUT,
    output logic INT_PEND
);

    logic                   shad_c;
    logic                   shad_z;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_last;
    logic                   s_prev;
    logic                   intr_event;
    logic                   c_ld_val;
    logic                   z_ld_val;

    assign c_ld_val   = FLG_LD_SEL ? shad_c : C_IN;
    assign z_ld_val   = FLG_LD_SEL ? shad_z : Z_IN;
    assign s_last     = sync_q[SYNC_STAGES-1];
    assign intr_event = EDGE_MODE ? (s_last & ~s_prev) : s_last;
    assign INT_OUT    = INT_PEND & I_FLAG;

    // Shadows sample the pre-edge flags, so a restore plus save in one cycle swaps them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            C_FLAG <= 1'b0;
            Z_FLAG <= 1'b0;
            shad_c <= 1'b0;
            shad_z <= 1'b0;
        end else begin
            if (FLG_C_CLR)
                C_FLAG <= 1'b0;
            else if (FLG_C_SET)
                C_FLAG <= 1'b1;
            else if (FLG_C_LD)
                C_FLAG <= c_ld_val;

            if (FLG_Z_LD)
                Z_FLAG <= z_ld_val;

            if (FLG_SHAD_LD) begin
                shad_c <= C_FLAG;
                shad_z <= Z_FLAG;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            I_FLAG <= 1'b0;
        else if (I_CLR)
            I_FLAG <= 1'b0;
        else if (I_SET)
            I_FLAG <= 1'b1;
    end

    // Pending is latched regardless of I_FLAG; an ack in the same cycle as an event drops the event.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q   <= '0;
            s_prev   <= 1'b0;
            INT_PEND <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], INTR};
            s_prev <= s_last;
            if (INT_ACK)
                INT_PEND <= 1'b0;
            else if (intr_event)
                INT_PEND <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rat_flags.sv
// Directed bench for rat_flags: stimulus queues expected flag vectors per edge; a monitor checks them.
module tb_rat_flags;

    logic CLK = 1'b0;
    logic RST, C_IN, Z_IN, FLG_C_LD, FLG_C_SET, FLG_C_CLR, FLG_Z_LD;
    logic FLG_LD_SEL, FLG_SHAD_LD, I_SET, I_CLR, INTR, INT_ACK;
    logic C_FLAG, Z_FLAG, I_FLAG, INT_OUT, INT_PEND;

    rat_flags #(.SYNC_STAGES(2), .EDGE_MODE(1'b1)) dut (
        .CLK(CLK), .RST(RST), .C_IN(C_IN), .Z_IN(Z_IN),
        .FLG_C_LD(FLG_C_LD), .FLG_C_SET(FLG_C_SET), .FLG_C_CLR(FLG_C_CLR),
        .FLG_Z_LD(FLG_Z_LD), .FLG_LD_SEL(FLG_LD_SEL), .FLG_SHAD_LD(FLG_SHAD_LD),
        .I_SET(I_SET), .I_CLR(I_CLR), .INTR(INTR), .INT_ACK(INT_ACK),
        .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .I_FLAG(I_FLAG),
        .INT_OUT(INT_OUT), .INT_PEND(INT_PEND)
    );

    always #5 CLK = ~CLK;

    // Vector bit order: {C_FLAG, Z_FLAG, I_FLAG, INT_PEND, INT_OUT}
    localparam logic [4:0] M_C = 5'b10000, M_Z = 5'b01000, M_I = 5'b00100;
    localparam logic [4:0] M_P = 5'b00010, M_O = 5'b00001, M_ALL = 5'b11111;

    typedef struct {
        int         cyc;
        logic [4:0] exp;
        logic [4:0] mask;
        string      name;
    } item_t;

    item_t sb[$];
    int    edge_n   = 0;
    int    checks   = 0;
    int    failures = 0;

    always @(posedge CLK) edge_n <= edge_n + 1;

    always @(negedge CLK) begin
        logic [4:0] got;
        item_t      it;
        got = {C_FLAG, Z_FLAG, I_FLAG, INT_PEND, INT_OUT};
        while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
            it = sb.pop_front();
            checks++;
            if (it.cyc != edge_n) begin
                failures++;
                $display("FAIL %s: sampled at edge %0d, required edge %0d", it.name, edge_n, it.cyc);
            end else if (((got ^ it.exp) & it.mask) != 5'b0) begin
                failures++;
                $display("FAIL %s: got CZIPO=%b required %b (mask %b)", it.name, got, it.exp, it.mask);
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [4:0] exp, input logic [4:0] mask);
        item_t it;
        it.cyc  = edge_n;
        it.exp  = exp;
        it.mask = mask;
        it.name = name;
        sb.push_back(it);
    endtask

    task automatic clr_ctl();
        RST = 0; C_IN = 0; Z_IN = 0; FLG_C_LD = 0; FLG_C_SET = 0; FLG_C_CLR = 0;
        FLG_Z_LD = 0; FLG_LD_SEL = 0; FLG_SHAD_LD = 0; I_SET = 0; I_CLR = 0; INT_ACK = 0;
    endtask

    initial begin
        clr_ctl();
        INTR = 0;

        // Reset overrides every other input
        RST = 1; C_IN = 1; Z_IN = 1; FLG_C_LD = 1; FLG_C_SET = 1; FLG_C_CLR = 1;
        FLG_Z_LD = 1; FLG_LD_SEL = 1; FLG_SHAD_LD = 1; I_SET = 1; I_CLR = 1;
        INT_ACK = 1; INTR = 1;
        cyc(); expect_out("reset0", 5'b00000, M_ALL);
        cyc(); expect_out("reset1", 5'b00000, M_ALL);
        clr_ctl(); INTR = 0;
        cyc(); expect_out("post_reset", 5'b00000, M_ALL);

        // ALU load then hold
        C_IN = 1; Z_IN = 1; FLG_C_LD = 1; FLG_Z_LD = 1;
        cyc(); expect_out("alu_load", 5'b11000, M_C | M_Z);
        clr_ctl();
        for (int i = 0; i < 3; i++) begin
            cyc(); expect_out("alu_hold", 5'b11000, M_C | M_Z);
        end

        // C priority: CLR > SET > LD; I: CLR > SET
        FLG_C_CLR = 1;
        cyc(); expect_out("c_clr", 5'b00000, M_C);
        FLG_C_SET = 1; FLG_C_LD = 1; C_IN = 1;
        cyc(); expect_out("prio_clr", 5'b00000, M_C);
        FLG_C_CLR = 0; C_IN = 0;
        cyc(); expect_out("prio_set", 5'b10000, M_C);
        FLG_C_SET = 0;
        cyc(); expect_out("ld_c0", 5'b00000, M_C);
        clr_ctl(); I_SET = 1;
        cyc(); expect_out("i_set", 5'b00100, M_I);
        I_CLR = 1;
        cyc(); expect_out("i_prio", 5'b00000, M_I);
        clr_ctl();

        // Save / restore / swap
        FLG_C_LD = 1; FLG_Z_LD = 1; C_IN = 1; Z_IN = 0;
        cyc(); expect_out("set_c1z0", 5'b10000, M_C | M_Z);
        clr_ctl(); FLG_SHAD_LD = 1;
        cyc(); expect_out("shad_save", 5'b10000, M_C | M_Z);
        clr_ctl(); FLG_C_LD = 1; FLG_Z_LD = 1; C_IN = 0; Z_IN = 1;
        cyc(); expect_out("alu_ovr", 5'b01000, M_C | M_Z);
        FLG_LD_SEL = 1;
        cyc(); expect_out("restore", 5'b10000, M_C | M_Z);
        FLG_LD_SEL = 0;
        cyc(); expect_out("alu_ovr2", 5'b01000, M_C | M_Z);
        FLG_LD_SEL = 1; FLG_SHAD_LD = 1;
        cyc(); expect_out("swap_flags", 5'b10000, M_C | M_Z);
        FLG_SHAD_LD = 0;
        cyc(); expect_out("swap_shad", 5'b01000, M_C | M_Z);
        clr_ctl();

        // Interrupt latency with I enabled
        I_SET = 1;
        cyc(); expect_out("int_en", 5'b00100, M_I | M_P | M_O);
        I_SET = 0; INTR = 1;
        cyc(); expect_out("lat_k", 5'b00100, M_I | M_P | M_O);
        cyc(); expect_out("lat_k1", 5'b00100, M_I | M_P | M_O);
        cyc(); expect_out("lat_k2", 5'b00111, M_I | M_P | M_O);
        INT_ACK = 1;
        cyc(); expect_out("ack", 5'b00100, M_I | M_P | M_O);
        INT_ACK = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(); expect_out("no_rearm", 5'b00000, M_P | M_O);
        end
        INTR = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(); expect_out("intr_low", 5'b00000, M_P | M_O);
        end

        // Masked pending, then unmask, then ack vs new edge
        I_CLR = 1;
        cyc(); expect_out("int_dis", 5'b00000, M_I | M_P | M_O);
        I_CLR = 0; INTR = 1;
        cyc(); expect_out("mask_m", 5'b00000, M_P | M_O);
        cyc(); expect_out("mask_m1", 5'b00000, M_P | M_O);
        cyc(); expect_out("masked_pend", 5'b00010, M_I | M_P | M_O);
        INTR = 0;
        cyc(); expect_out("masked_hold", 5'b00010, M_I | M_P | M_O);
        I_SET = 1;
        cyc(); expect_out("unmask", 5'b00111, M_I | M_P | M_O);
        I_SET = 0;
        cyc(); expect_out("pend_hold0", 5'b00111, M_I | M_P | M_O);
        cyc(); expect_out("pend_hold1", 5'b00111, M_I | M_P | M_O);
        INTR = 1;
        cyc(); expect_out("edge_n0", 5'b00011, M_P | M_O);
        cyc(); expect_out("edge_n1", 5'b00011, M_P | M_O);
        INT_ACK = 1;
        cyc(); expect_out("ack_vs_edge", 5'b00100, M_I | M_P | M_O);
        INT_ACK = 0;
        cyc(); expect_out("edge_lost", 5'b00000, M_P | M_O);

        // Reset mid-interrupt wipes flags and pending
        INTR = 0;
        cyc(); cyc();
        INTR = 1;
        cyc(); cyc(); cyc(); expect_out("pend_again", 5'b00111, M_I | M_P | M_O);
        RST = 1;
        cyc(); expect_out("reset_mid", 5'b00000, M_ALL);
        RST = 0;
        cyc(); expect_out("after_reset_mid", 5'b00000, M_ALL);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge CLK);
        #1;
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations never checked, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rat_flags.md
Name: rat_flags

Overview:
- Status-flag and interrupt-gating stage that sits directly downstream of the RAT ALU.
- Registers the ALU's C and Z outputs under control-unit command, and feeds C_FLAG back to the ALU CIN input and to the branch logic.
- Holds shadow copies of C/Z for interrupt save/restore and the interrupt-enable flag I.
- Synchronizes the external interrupt request and presents a gated interrupt to the control unit.

Parameters:
SYNC_STAGES, 2, number of flip-flop stages on INTR before edge detection (legal 2..4)
EDGE_MODE, 1, 1 = rising-edge-triggered interrupt capture, 0 = level-triggered (pending follows synchronized level)

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
C_IN  input  1  carry result from ALU
Z_IN  input  1  zero result from ALU
FLG_C_LD  input  1  load C_FLAG from C_IN (or shadow when FLG_LD_SEL=1)
FLG_C_SET  input  1  force C_FLAG to 1
FLG_C_CLR  input  1  force C_FLAG to 0
FLG_Z_LD  input  1  load Z_FLAG from Z_IN (or shadow when FLG_LD_SEL=1)
FLG_LD_SEL  input  1  0 = load source is ALU, 1 = load source is shadow (RETIE restore)
FLG_SHAD_LD  input  1  copy current C_FLAG/Z_FLAG into shadows
I_SET  input  1  set interrupt enable (SEI)
I_CLR  input  1  clear interrupt enable (CLI, interrupt entry)
INTR  input  1  external interrupt request, not synchronous to CLK
INT_ACK  input  1  control unit has entered interrupt state; clears pending
C_FLAG  output  1  registered carry flag
Z_FLAG  output  1  registered zero flag
I_FLAG  output  1  registered interrupt-enable flag
INT_OUT  output  1  interrupt request to control unit = INT_PEND & I_FLAG (combinational from registers)
INT_PEND  output  1  registered pending-interrupt latch

Behaviour:
- Clocking/reset: one clock, CLK; RST synchronous, active-high. On a rising edge with RST=1, C_FLAG, Z_FLAG, I_FLAG, both shadows, all sync stages, the edge-history flop and INT_PEND go to 0. RST overrides every other input in that cycle. INT_OUT is therefore 0 the cycle after reset. Reset mid-interrupt discards the pending request and all saved state.
- C_FLAG next-state priority: RST > FLG_C_CLR > FLG_C_SET > FLG_C_LD > hold.
  - Load value is C_IN when FLG_LD_SEL=0, SHAD_C when FLG_LD_SEL=1.
- Z_FLAG next-state priority: RST > FLG_Z_LD > hold.
  - Load value is Z_IN when FLG_LD_SEL=0, SHAD_Z when FLG_LD_SEL=1.
- Shadows: on FLG_SHAD_LD, SHAD_C/SHAD_Z capture the pre-edge C_FLAG/Z_FLAG values, i.e. the values before any same-cycle flag update.
  - Simultaneous FLG_SHAD_LD and FLG_LD_SEL=1 load swaps the contents: flags take the old shadows, shadows take the old flags.
- I_FLAG: RST > I_CLR > I_SET > hold. I_CLR wins when both are asserted.
- All flag loads take effect one cycle after the command; there is no combinational path from C_IN/Z_IN to outputs.
- Interrupt path:
  - INTR passes through SYNC_STAGES flops to give s_last. A history flop s_prev registers s_last.
  - EDGE_MODE=1: a rise is detected when s_last & ~s_prev. INTR first sampled high at edge k gives INT_PEND=1 after edge k+SYNC_STAGES.
  - EDGE_MODE=0: INT_PEND is set whenever s_last=1.
  - INT_PEND priority: RST > INT_ACK (clear) > detected event (set) > hold.
  - Event and INT_ACK in the same cycle: INT_ACK wins and the event is lost; the control unit asserts INT_ACK only while INT_OUT=1.
  - INT_PEND is latched independent of I_FLAG, so a request arriving while interrupts are disabled is serviced as soon as I_SET is applied.
  - A held-high INTR in EDGE_MODE=1 produces exactly one pending event. It must go low for at least one synchronized cycle to re-arm.
- No X propagation: all registers are defined after reset; inputs are sampled only on the clock edge.

Test Plan:
- Reset: drive all controls 1, INTR=1, RST=1 for 2 cycles -> C_FLAG=Z_FLAG=I_FLAG=INT_PEND=INT_OUT=0 after each edge.
- ALU load: C_IN=1, Z_IN=1, FLG_C_LD=FLG_Z_LD=1, FLG_LD_SEL=0 for one cycle, then C_IN=0 with no loads -> C_FLAG=1, Z_FLAG=1, held for the following 3 cycles.
- Priority: C_FLAG=0, assert FLG_C_CLR=FLG_C_SET=FLG_C_LD=1 with C_IN=1 -> C_FLAG=0. Drop CLR -> C_FLAG=1 next edge. I_SET=I_CLR=1 -> I_FLAG=0.
- Save/restore: flags C=1,Z=0, pulse FLG_SHAD_LD. Load ALU C=0,Z=1. Assert FLG_C_LD=FLG_Z_LD=1 with FLG_LD_SEL=1 -> C_FLAG=1, Z_FLAG=0. Repeat with FLG_SHAD_LD in the same cycle -> shadows become C=0,Z=1 (swap).
- Interrupt latency, SYNC_STAGES=2, EDGE_MODE=1: I_FLAG=1, INTR rises before edge k and stays high 10 cycles -> INT_PEND=1 and INT_OUT=1 after edge k+2. INT_ACK for one cycle -> INT_PEND=0 and stays 0 while INTR remains high.
- Masked pending: I_FLAG=0, INTR pulse 3 cycles wide -> INT_PEND=1, INT_OUT=0. Later I_SET -> INT_OUT=1 the cycle after the I_SET edge. INT_ACK coincident with a new detected edge -> INT_PEND=0.
